// File: rtl/pong_pkg.sv
// Shared widths, state type and overlap helper for the pong game blocks.
package pong_pkg;

    localparam int COORD_W = 10;
    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SERVE,
        PLAY,
        GAME_OVER
    } ball_state_t;

    // True when ball and paddle share at least one row; sums are one bit wider so they never wrap.
    function automatic logic y_overlap(
        input logic [COORD_W-1:0] ball_y,
        input logic [COORD_W-1:0] paddle_y,
        input int                 ball_size,
        input int                 paddle_h
    );
        logic [COORD_W:0] ball_bot;
        logic [COORD_W:0] paddle_bot;
        ball_bot   = {1'b0, ball_y} + (COORD_W + 1)'(ball_size);
        paddle_bot = {1'b0, paddle_y} + (COORD_W + 1)'(paddle_h);
        return (ball_bot > {1'b0, paddle_y}) && ({1'b0, ball_y} < paddle_bot);
    endfunction

endpackage

// File: rtl/tick_detect.sv
// Turns a slow toggling level from the clock divider into a one-cycle rising-edge tick.
module tick_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic tick
);

    logic level_q;

    // NOTE: sequential state is only ever written with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign tick = level & ~level_q;

endmodule

// File: rtl/pong_ball_engine.sv
// Ball motion, bounce, paddle-hit, scoring and serve sequencing for the pong game.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_XL   = 16,
    parameter int PADDLE_XR   = 616,
    parameter int STEP_TICKS  = 4,
    parameter int SERVE_TICKS = 500,
    parameter int WIN_SCORE   = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_1ms,
    input  logic               start,
    input  logic [COORD_W-1:0] paddle_l_y,
    input  logic [COORD_W-1:0] paddle_r_y,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               point_l,
    output logic               point_r,
    output logic               game_over
);

    localparam int STEP_CW  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int SERVE_CW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

    localparam logic [COORD_W-1:0]  X_MAX      = COORD_W'(SCREEN_W - BALL_SIZE);
    localparam logic [COORD_W-1:0]  Y_MAX      = COORD_W'(SCREEN_H - BALL_SIZE);
    localparam logic [COORD_W-1:0]  X_CENTRE   = COORD_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0]  Y_CENTRE   = COORD_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [COORD_W-1:0]  X_HIT_L    = COORD_W'(PADDLE_XL + PADDLE_W);
    localparam logic [COORD_W-1:0]  X_HIT_R    = COORD_W'(PADDLE_XR - BALL_SIZE);
    localparam logic [STEP_CW-1:0]  STEP_LAST  = STEP_CW'(STEP_TICKS - 1);
    localparam logic [SERVE_CW-1:0] SERVE_LAST = SERVE_CW'(SERVE_TICKS - 1);
    localparam logic [SCORE_W-1:0]  WIN        = SCORE_W'(WIN_SCORE);

    logic                tick;
    ball_state_t         state, state_n;
    logic [STEP_CW-1:0]  step_cnt, step_n;
    logic [SERVE_CW-1:0] serve_cnt, serve_n;
    logic [COORD_W-1:0]  x_n, y_n;
    logic                dx_neg, dx_neg_n;
    logic                dy_neg, dy_neg_n;
    logic [SCORE_W-1:0]  score_l_n, score_r_n;
    logic                point_l_n, point_r_n;
    logic                step_now, hit_l, hit_r;

    tick_detect u_tick_detect (
        .clk  (clk),
        .rst_n(rst_n),
        .level(clk_1ms),
        .tick (tick)
    );

    assign hit_l = dx_neg && (ball_x == X_HIT_L)
                   && y_overlap(ball_y, paddle_l_y, BALL_SIZE, PADDLE_H);
    assign hit_r = !dx_neg && (ball_x == X_HIT_R)
                   && y_overlap(ball_y, paddle_r_y, BALL_SIZE, PADDLE_H);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_cnt  <= '0;
            serve_cnt <= '0;
            ball_x    <= X_CENTRE;
            ball_y    <= Y_CENTRE;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            score_l   <= '0;
            score_r   <= '0;
            point_l   <= 1'b0;
            point_r   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            state     <= state_n;
            step_cnt  <= step_n;
            serve_cnt <= serve_n;
            ball_x    <= x_n;
            ball_y    <= y_n;
            dx_neg    <= dx_neg_n;
            dy_neg    <= dy_neg_n;
            score_l   <= score_l_n;
            score_r   <= score_r_n;
            point_l   <= point_l_n;
            point_r   <= point_r_n;
            game_over <= (state_n == GAME_OVER);
        end
    end

    // NOTE: every signal gets its hold value first so no path through this block infers a latch.
    always_comb begin
        state_n   = state;
        step_n    = step_cnt;
        serve_n   = serve_cnt;
        x_n       = ball_x;
        y_n       = ball_y;
        dx_neg_n  = dx_neg;
        dy_neg_n  = dy_neg;
        score_l_n = score_l;
        score_r_n = score_r;
        point_l_n = 1'b0;
        point_r_n = 1'b0;
        step_now  = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = SERVE;
                    serve_n = '0;
                    step_n  = '0;
                end
            end
            SERVE: begin
                x_n = X_CENTRE;
                y_n = Y_CENTRE;
                if (tick) begin
                    if (serve_cnt == SERVE_LAST) begin
                        serve_n = '0;
                        step_n  = '0;
                        state_n = PLAY;
                    end else begin
                        serve_n = serve_cnt + 1'b1;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    if (step_cnt == STEP_LAST) begin
                        step_n   = '0;
                        step_now = 1'b1;
                    end else begin
                        step_n = step_cnt + 1'b1;
                    end
                end
            end
            GAME_OVER: begin
                if (start) begin
                    score_l_n = '0;
                    score_r_n = '0;
                    dx_neg_n  = 1'b0;
                    state_n   = SERVE;
                    serve_n   = '0;
                    step_n    = '0;
                    x_n       = X_CENTRE;
                    y_n       = Y_CENTRE;
                end
            end
        endcase

        // A miss freezes y and re-serves toward the side that just lost the point.
        if (step_now) begin
            if (dx_neg && (ball_x == '0)) begin
                point_r_n = 1'b1;
                score_r_n = (score_r == WIN) ? score_r : score_r + 1'b1;
                dx_neg_n  = 1'b1;
                if (score_r_n == WIN) begin
                    state_n = GAME_OVER;
                end else begin
                    state_n = SERVE;
                    serve_n = '0;
                    x_n     = X_CENTRE;
                    y_n     = Y_CENTRE;
                end
            end else if (!dx_neg && (ball_x == X_MAX)) begin
                point_l_n = 1'b1;
                score_l_n = (score_l == WIN) ? score_l : score_l + 1'b1;
                dx_neg_n  = 1'b0;
                if (score_l_n == WIN) begin
                    state_n = GAME_OVER;
                end else begin
                    state_n = SERVE;
                    serve_n = '0;
                    x_n     = X_CENTRE;
                    y_n     = Y_CENTRE;
                end
            end else begin
                if (hit_l) begin
                    dx_neg_n = 1'b0;
                    x_n      = ball_x + 1'b1;
                end else if (hit_r) begin
                    dx_neg_n = 1'b1;
                    x_n      = ball_x - 1'b1;
                end else begin
                    x_n = dx_neg ? ball_x - 1'b1 : ball_x + 1'b1;
                end

                if (dy_neg ? (ball_y == '0) : (ball_y == Y_MAX)) begin
                    dy_neg_n = !dy_neg;
                    y_n      = dy_neg ? ball_y + 1'b1 : ball_y - 1'b1;
                end else begin
                    y_n = dy_neg ? ball_y - 1'b1 : ball_y + 1'b1;
                end
            end
        end
    end

endmodule
